mult_div_unit: RTL

Sequential, parametrised multiply/divide unit with architectural HI/LO registers. It replaces the combinational 64-bit multiply/divide path in the datapath ALU. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO using iterative radix-2 shift-add and restoring-division cores behind a start/busy/done handshake. The pipeline stalls on `busy` before issuing any further multiply/divide or HI/LO access.

---
 rtl/mdu_pkg.sv | 31 +++
 rtl/mult_div_unit_if.sv | 19 +
 rtl/mult_div_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types for the sequential multiply/divide unit.
package mdu_pkg;

    localparam int unsigned MDU_OP_W = 3;

    typedef enum logic [MDU_OP_W-1:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

    // True for the operations that treat operands as two's complement.
    function automatic logic is_signed_op(input mdu_op_t op);
        return (op == MULT) || (op == DIV);
    endfunction

    // True for the divide family (selects the divide iteration and result map).
    function automatic logic is_div_op(input mdu_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the pipeline and the multiply/divide unit.
interface mult_div_unit_if
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    logic                start;
    logic [MDU_OP_W-1:0] op;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic                busy;
    logic                done;
    logic [WIDTH-1:0]    hi;
    logic [WIDTH-1:0]    lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);

endinterface

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply / restoring divide with architectural HI/LO.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mult_div_unit_if.slave    bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned ACC_W = 2 * WIDTH;

    mdu_state_t        state;
    mdu_op_t           op_r;
    logic [CNT_W-1:0]  cnt;
    logic [ACC_W-1:0]  acc;
    logic [WIDTH-1:0]  opnd;
    logic              neg_q;
    logic              neg_r;
    logic [WIDTH-1:0]  hi_r;
    logic [WIDTH-1:0]  lo_r;
    logic              done_r;

    mdu_op_t           op_in;
    logic              in_signed;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic              div_zero;
    logic              div_ovf;

    logic [WIDTH:0]    mul_sum;
    logic [ACC_W-1:0]  mul_next;
    logic [WIDTH:0]    div_trial;
    logic              div_ge;
    logic [WIDTH-1:0]  div_rem;
    logic [ACC_W-1:0]  div_next;

    logic [ACC_W-1:0]  prod_fix;
    logic [WIDTH-1:0]  quo_fix;
    logic [WIDTH-1:0]  rem_fix;

    // Request decode: operand magnitudes and special-case divides.
    always_comb begin
        op_in     = mdu_op_t'(bus.op);
        in_signed = is_signed_op(op_in);
        a_mag     = (in_signed && bus.a[WIDTH-1]) ? WIDTH'(WIDTH'(0) - bus.a) : bus.a;
        b_mag     = (in_signed && bus.b[WIDTH-1]) ? WIDTH'(WIDTH'(0) - bus.b) : bus.b;
        div_zero  = (bus.b == '0);
        div_ovf   = (op_in == DIV) && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
    end

    // One iteration step of each core; both operate on the shared accumulator.
    always_comb begin
        mul_sum   = {1'b0, acc[ACC_W-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_trial = {acc[ACC_W-1:WIDTH], acc[WIDTH-1]};
        div_ge    = (div_trial >= {1'b0, opnd});
        div_rem   = div_ge ? WIDTH'(div_trial - {1'b0, opnd}) : div_trial[WIDTH-1:0];
        div_next  = {div_rem, acc[WIDTH-2:0], div_ge};
    end

    // Sign correction applied in FIX (special divides arrive with flags cleared).
    always_comb begin
        prod_fix = neg_q ? ACC_W'(ACC_W'(0) - acc) : acc;
        quo_fix  = neg_q ? WIDTH'(WIDTH'(0) - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        rem_fix  = neg_r ? WIDTH'(WIDTH'(0) - acc[ACC_W-1:WIDTH]) : acc[ACC_W-1:WIDTH];
    end

    // Control FSM, iteration datapath and HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_r   <= MULT;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (op_in)
                            MTHI: hi_r <= bus.a;
                            MTLO: lo_r <= bus.a;
                            MULT, MULTU: begin
                                op_r  <= op_in;
                                opnd  <= a_mag;
                                acc   <= {{WIDTH{1'b0}}, b_mag};
                                neg_q <= in_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                                neg_r <= 1'b0;
                                cnt   <= '0;
                                state <= CALC;
                            end
                            DIV, DIVU: begin
                                op_r <= op_in;
                                cnt  <= '0;
                                if (div_zero) begin
                                    acc   <= {bus.a, {WIDTH{1'b1}}};
                                    neg_q <= 1'b0;
                                    neg_r <= 1'b0;
                                    state <= FIX;
                                end else if (div_ovf) begin
                                    acc   <= {{WIDTH{1'b0}}, bus.a};
                                    neg_q <= 1'b0;
                                    neg_r <= 1'b0;
                                    state <= FIX;
                                end else begin
                                    opnd  <= b_mag;
                                    acc   <= {{WIDTH{1'b0}}, a_mag};
                                    neg_q <= in_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                                    neg_r <= in_signed & bus.a[WIDTH-1];
                                    state <= CALC;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    acc <= is_div_op(op_r) ? div_next : mul_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (is_div_op(op_r)) begin
                        hi_r <= rem_fix;
                        lo_r <= quo_fix;
                    end else begin
                        hi_r <= prod_fix[ACC_W-1:WIDTH];
                        lo_r <= prod_fix[WIDTH-1:0];
                    end
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake and architectural outputs come straight from registers.
    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule
